// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions for the exception/interrupt unit.
// Contents: CP0 register numbers, ExcCode values, and STATUS/CAUSE bit positions.
package cp0_exc_unit_pkg;

    localparam logic [4:0] SEL_STATUS = 5'd12;
    localparam logic [4:0] SEL_CAUSE  = 5'd13;
    localparam logic [4:0] SEL_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int ST_IE       = 0;
    localparam int ST_EXL      = 1;
    localparam int ST_IM_LSB   = 8;
    localparam int CA_CODE_LSB = 2;
    localparam int CA_IP_LSB   = 8;

endpackage

// File: rtl/cp0_exc_prio.sv
// Combinational priority encoder for the CP0 exception unit.
// Ports:
//   inst_valid            current instruction is real
//   exc_ri/exc_sys/exc_ovf synchronous exception requests
//   irq_pend              enabled, unmasked interrupt pending
//   eret, exl             eret decoded, current STATUS.EXL
//   take                  exception/interrupt taken (redirect to vector)
//   code                  ExcCode for the taken event
//   is_ret                eret return to EPC
module cp0_exc_prio
    import cp0_exc_unit_pkg::*;
#(
    parameter bit ERET_RI = 1'b1
) (
    input  logic       inst_valid,
    input  logic       exc_ri,
    input  logic       exc_sys,
    input  logic       exc_ovf,
    input  logic       irq_pend,
    input  logic       eret,
    input  logic       exl,
    output logic       take,
    output logic [4:0] code,
    output logic       is_ret
);

    always_comb begin
        take   = 1'b0;
        code   = EXC_INT;
        is_ret = 1'b0;
        if (inst_valid) begin
            // An eret outside a handler is treated as an illegal instruction when enabled.
            if (exc_ri || (ERET_RI && eret && !exl)) begin
                take = 1'b1;
                code = EXC_RI;
            end else if (exc_sys) begin
                take = 1'b1;
                code = EXC_SYS;
            end else if (exc_ovf) begin
                take = 1'b1;
                code = EXC_OV;
            end else if (irq_pend) begin
                take = 1'b1;
                code = EXC_INT;
            end else if (eret && exl) begin
                is_ret = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception/interrupt unit for the single-cycle MIPS core.
// Holds STATUS/CAUSE/EPC, arbitrates interrupts against synchronous exceptions and
// steers the PC mux to the handler vector or back to EPC.
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   Inst_valid, Pc  current instruction qualifier and address
//   Irq             level-sensitive interrupt requests
//   Exc_ri/sys/ovf  synchronous exception requests
//   Mtc0/Mfc0/Eret  CP0 instructions; Sel is the CP0 register, Wdata the mtc0 data
//   Rdata           CP0 read data (combinational on Sel)
//   Take/Target     PC redirect and its destination
//   Kill            suppress writes of the current instruction
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter int          NUM_IRQ = 4,
    parameter logic [31:0] VECTOR  = 32'h0000_0008,
    parameter bit          ERET_RI = 1'b1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Inst_valid,
    input  logic [31:0]        Pc,
    input  logic [NUM_IRQ-1:0] Irq,
    input  logic               Exc_ri,
    input  logic               Exc_sys,
    input  logic               Exc_ovf,
    input  logic               Mtc0,
    input  logic               Mfc0,
    input  logic               Eret,
    input  logic [4:0]         Sel,
    input  logic [31:0]        Wdata,
    output logic [31:0]        Rdata,
    output logic               Take,
    output logic [31:0]        Target,
    output logic               Kill
);

    logic               ie;
    logic               exl;
    logic [NUM_IRQ-1:0] im;
    logic [NUM_IRQ-1:0] ip;
    logic [4:0]         exc_code;
    logic [31:0]        epc;

    logic               irq_pend;
    logic               take;
    logic               is_ret;
    logic [4:0]         code;

    // Rdata is driven purely by Sel; EPC low bits are forced to zero.
    logic unused_bits;
    assign unused_bits = ^{Mfc0, Pc[1:0]};

    assign irq_pend = ie & ~exl & (|(ip & im));

    cp0_exc_prio #(
        .ERET_RI (ERET_RI)
    ) u_prio (
        .inst_valid (Inst_valid),
        .exc_ri     (Exc_ri),
        .exc_sys    (Exc_sys),
        .exc_ovf    (Exc_ovf),
        .irq_pend   (irq_pend),
        .eret       (Eret),
        .exl        (exl),
        .take       (take),
        .code       (code),
        .is_ret     (is_ret)
    );

    assign Take   = take | is_ret;
    assign Kill   = take;
    assign Target = take ? VECTOR : epc;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ie       <= 1'b0;
            exl      <= 1'b0;
            im       <= '0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            // IP samples the lines every cycle so requests are seen one cycle late.
            ip <= Irq;
            if (take) begin
                epc      <= {Pc[31:2], 2'b00};
                exl      <= 1'b1;
                exc_code <= code;
            end else if (is_ret) begin
                exl <= 1'b0;
            end else if (Inst_valid && Mtc0) begin
                if (Sel == SEL_STATUS) begin
                    ie  <= Wdata[ST_IE];
                    exl <= Wdata[ST_EXL];
                    im  <= Wdata[ST_IM_LSB +: NUM_IRQ];
                end else if (Sel == SEL_EPC) begin
                    epc <= {Wdata[31:2], 2'b00};
                end
            end
        end
    end

    always_comb begin
        Rdata = '0;
        case (Sel)
            SEL_STATUS: begin
                Rdata[ST_IE]                 = ie;
                Rdata[ST_EXL]                = exl;
                Rdata[ST_IM_LSB +: NUM_IRQ]  = im;
            end
            SEL_CAUSE: begin
                Rdata[CA_CODE_LSB +: 5]      = exc_code;
                Rdata[CA_IP_LSB +: NUM_IRQ]  = ip;
            end
            SEL_EPC: Rdata = epc;
            default: Rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios followed by random
// stimulus compared against a behavioural model of the CP0 registers.
module tb_cp0_exc_unit;

    localparam int          N   = 4;
    localparam logic [31:0] VEC = 32'h0000_0008;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Inst_valid;
    logic [31:0]   Pc;
    logic [N-1:0]  Irq;
    logic          Exc_ri, Exc_sys, Exc_ovf;
    logic          Mtc0, Mfc0, Eret;
    logic [4:0]    Sel;
    logic [31:0]   Wdata;
    logic [31:0]   Rdata;
    logic          Take;
    logic [31:0]   Target;
    logic          Kill;

    always #5 Clk = ~Clk;

    cp0_exc_unit #(.NUM_IRQ(N), .VECTOR(VEC), .ERET_RI(1'b1)) dut (
        .Clk(Clk), .Rst(Rst), .Inst_valid(Inst_valid), .Pc(Pc), .Irq(Irq),
        .Exc_ri(Exc_ri), .Exc_sys(Exc_sys), .Exc_ovf(Exc_ovf),
        .Mtc0(Mtc0), .Mfc0(Mfc0), .Eret(Eret), .Sel(Sel), .Wdata(Wdata),
        .Rdata(Rdata), .Take(Take), .Target(Target), .Kill(Kill)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model of the architectural CP0 state.
    logic         m_ie, m_exl;
    logic [N-1:0] m_im, m_ip;
    logic [4:0]   m_code;
    logic [31:0]  m_epc;

    function automatic logic [31:0] model_read(input logic [4:0] s);
        case (s)
            5'd12:   return (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13:   return (32'(m_ip) << 8) | (32'(m_code) << 2);
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_eval(output bit t, output bit r, output logic [4:0] c);
        bit pend;
        pend = m_ie && !m_exl && ((m_ip & m_im) != '0);
        t = 0; r = 0; c = 5'd0;
        if (Inst_valid) begin
            if (Exc_ri || (Eret && !m_exl)) begin t = 1; c = 5'd10; end
            else if (Exc_sys)                begin t = 1; c = 5'd8;  end
            else if (Exc_ovf)                begin t = 1; c = 5'd12; end
            else if (pend)                   begin t = 1; c = 5'd0;  end
            else if (Eret)                   r = 1;
        end
    endtask

    // One clock cycle: optionally compare outputs against the model, then advance both.
    task automatic step(input string tag, input bit do_chk);
        bit t, r;
        logic [4:0] c;
        #1;
        model_eval(t, r, c);
        if (do_chk) begin
            chk({tag, ".take"}, 32'(Take), 32'(t | r));
            chk({tag, ".kill"}, 32'(Kill), 32'(t));
            if (t | r) chk({tag, ".target"}, Target, t ? VEC : m_epc);
            chk({tag, ".rdata"}, Rdata, model_read(Sel));
        end
        @(posedge Clk);
        if (Rst) begin
            m_ie = 0; m_exl = 0; m_im = '0; m_ip = '0; m_code = '0; m_epc = '0;
        end else begin
            if (t) begin
                m_epc = {Pc[31:2], 2'b00}; m_exl = 1; m_code = c;
            end else if (r) begin
                m_exl = 0;
            end else if (Inst_valid && Mtc0) begin
                if (Sel == 5'd12) begin
                    m_ie = Wdata[0]; m_exl = Wdata[1]; m_im = Wdata[8 +: N];
                end else if (Sel == 5'd14) begin
                    m_epc = {Wdata[31:2], 2'b00};
                end
            end
            m_ip = Irq;
        end
        #1;
    endtask

    task automatic idle();
        Rst = 0; Inst_valid = 0; Exc_ri = 0; Exc_sys = 0; Exc_ovf = 0;
        Mtc0 = 0; Mfc0 = 0; Eret = 0; Sel = 5'd0; Wdata = '0;
    endtask

    task automatic read_reg(input string tag, input logic [4:0] s, input logic [31:0] exp);
        idle();
        Sel = s; Mfc0 = 1;
        #1;
        chk(tag, Rdata, exp);
        step(tag, 1);
    endtask

    initial begin
        idle();
        Pc = 32'h0; Irq = '0;
        m_ie = 0; m_exl = 0; m_im = '0; m_ip = '0; m_code = '0; m_epc = '0;

        // Reset
        Rst = 1;
        step("rst0", 0);
        step("rst1", 1);
        Rst = 0;
        read_reg("rst_status", 5'd12, 32'h0);
        read_reg("rst_cause",  5'd13, 32'h0);
        read_reg("rst_epc",    5'd14, 32'h0);

        // Interrupt
        idle(); Inst_valid = 1; Mtc0 = 1; Sel = 5'd12; Wdata = 32'h0000_0201; Pc = 32'h3c;
        step("irq_mtc0", 1);
        idle(); Irq = 4'b0010; Pc = 32'h40;
        step("irq_bubble", 1);
        idle(); Inst_valid = 1; Pc = 32'h40;
        #1;
        chk("irq_take", 32'(Take), 32'h1);
        chk("irq_kill", 32'(Kill), 32'h1);
        chk("irq_target", Target, 32'h8);
        step("irq_cycle", 1);
        read_reg("irq_epc",    5'd14, 32'h40);
        read_reg("irq_cause",  5'd13, 32'h0000_0200);
        read_reg("irq_status", 5'd12, 32'h0000_0203);

        // Masking by EXL, then by IM=0
        Irq = 4'hF;
        for (int i = 0; i < 10; i++) begin
            idle(); Inst_valid = 1; Pc = 32'h100 + 32'(i * 4);
            #1; chk("mask_exl", 32'(Take), 32'h0);
            step("mask_exl_cyc", 1);
        end
        read_reg("mask_cause", 5'd13, 32'h0000_0F00);
        idle(); Inst_valid = 1; Mtc0 = 1; Sel = 5'd12; Wdata = 32'h0000_0001;
        step("mask_im_mtc0", 1);
        for (int i = 0; i < 10; i++) begin
            idle(); Inst_valid = 1; Pc = 32'h200 + 32'(i * 4);
            #1; chk("mask_im", 32'(Take), 32'h0);
            step("mask_im_cyc", 1);
        end

        // Priority: sys beats ovf and irq
        idle(); Inst_valid = 1; Mtc0 = 1; Sel = 5'd12; Wdata = 32'h0000_0F01;
        step("prio_mtc0", 1);
        idle(); Inst_valid = 1; Exc_ovf = 1; Exc_sys = 1; Pc = 32'h80;
        #1; chk("prio_take", 32'(Take), 32'h1);
        step("prio_cycle", 1);
        read_reg("prio_epc",   5'd14, 32'h80);
        read_reg("prio_cause", 5'd13, 32'h0000_0F20);

        // Eret return and eret outside handler
        Irq = '0;
        idle(); Inst_valid = 1; Mtc0 = 1; Sel = 5'd14; Wdata = 32'h44;
        step("eret_mtc0", 1);
        idle(); Inst_valid = 1; Eret = 1; Pc = 32'h90;
        #1;
        chk("eret_take", 32'(Take), 32'h1);
        chk("eret_kill", 32'(Kill), 32'h0);
        chk("eret_target", Target, 32'h44);
        step("eret_cycle", 1);
        read_reg("eret_status", 5'd12, 32'h0000_0F01);
        idle(); Inst_valid = 1; Eret = 1; Pc = 32'h94;
        #1;
        chk("eret_ri_take", 32'(Take), 32'h1);
        chk("eret_ri_kill", 32'(Kill), 32'h1);
        chk("eret_ri_target", Target, 32'h8);
        step("eret_ri_cycle", 1);
        read_reg("eret_ri_cause", 5'd13, 32'h0000_0028);
        read_reg("eret_ri_epc",   5'd14, 32'h94);

        // Collisions
        idle(); Rst = 1; Inst_valid = 1; Exc_sys = 1; Pc = 32'hC0;
        step("col_rst", 1);
        read_reg("col_rst_status", 5'd12, 32'h0);
        read_reg("col_rst_cause",  5'd13, 32'h0);
        read_reg("col_rst_epc",    5'd14, 32'h0);
        idle(); Inst_valid = 1; Exc_ri = 1; Mtc0 = 1; Sel = 5'd14; Wdata = 32'h1234; Pc = 32'hA0;
        step("col_mtc0", 1);
        read_reg("col_mtc0_epc", 5'd14, 32'hA0);
        idle(); Exc_ri = 1; Pc = 32'hB0;
        #1; chk("col_bubble_take", 32'(Take), 32'h0);
        step("col_bubble", 1);
        read_reg("col_bubble_epc",   5'd14, 32'hA0);
        read_reg("col_bubble_cause", 5'd13, 32'h0000_0028);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            idle();
            Rst        = ($urandom_range(0, 49) == 0);
            Inst_valid = ($urandom_range(0, 9) != 0);
            Pc         = $urandom;
            Irq        = N'($urandom);
            Exc_ri     = ($urandom_range(0, 11) == 0);
            Exc_sys    = ($urandom_range(0, 11) == 0);
            Exc_ovf    = ($urandom_range(0, 11) == 0);
            Eret       = ($urandom_range(0, 7) == 0);
            Mtc0       = ($urandom_range(0, 3) == 0);
            Mfc0       = ($urandom_range(0, 3) == 0);
            Sel        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 2));
            Wdata      = $urandom;
            step("rand", 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
